// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module  : hazard_forward_unit
// Brief   : Hazard detection, operand forwarding, load-use stall, branch flush
//           and multi-cycle DMEM hold for the 5-stage negedge pipeline.
//           Optional macro HAZ_PERF_CNT_EN adds stall/flush/hold counters.
// Rev     : 1.0
// ============================================================================
module hazard_forward_unit #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int MEM_LATENCY = 1,
  parameter int FLUSH_DEPTH = 1
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic              d_use_rs,
  input  logic              d_use_rt,
  input  logic              d_regwrite,
  input  logic              d_memread,
  input  logic              d_memwrite,
  input  logic [REG_AW-1:0] d_dest,
  input  logic [DATA_W-1:0] d_rs_data,
  input  logic [DATA_W-1:0] d_rt_data,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [DATA_W-1:0] wb_result,
  input  logic              ex_branch_taken,
  output logic              stall_fd,
  output logic              bubble_ex,
  output logic              flush_fd,
  output logic              mem_hold,
  output logic [1:0]        fwd_sel_a,
  output logic [1:0]        fwd_sel_b,
  output logic [DATA_W-1:0] fwd_a,
  output logic [DATA_W-1:0] fwd_b
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt,
  output logic [31:0]       perf_hold_cnt
`endif
);

  localparam int c_hold_w  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int c_flush_w = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
  localparam logic [c_hold_w-1:0]  c_hold_load  = c_hold_w'(MEM_LATENCY - 1);
  localparam logic [c_flush_w-1:0] c_flush_load = c_flush_w'(FLUSH_DEPTH - 1);

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              memread;
    logic              memop;
    logic [REG_AW-1:0] dest;
  } sb_entry_t;

  sb_entry_t             r_ex, r_mem, r_wb, w_d_entry;
  logic [c_hold_w-1:0]   r_hold_cnt;
  logic [c_flush_w-1:0]  r_flush_cnt;
  logic                  w_ex_a, w_mem_a, w_wb_a, w_ex_b, w_mem_b, w_wb_b;
  logic                  w_load_use;
  logic                  w_unused;

  function automatic logic hit(input sb_entry_t e, input logic [REG_AW-1:0] src,
                               input logic use_bit);
    return e.valid & e.regwrite & (e.dest == src) & (src != '0) & use_bit;
  endfunction

  function automatic logic [1:0] pick_sel(input logic ex_hit, input logic mem_hit,
                                          input logic wb_hit);
    if (ex_hit)       return 2'd3;
    else if (mem_hit) return 2'd2;
    else if (wb_hit)  return 2'd1;
    else              return 2'd0;
  endfunction

  assign w_d_entry = '{valid: 1'b1, regwrite: d_regwrite, memread: d_memread,
                       memop: d_memread | d_memwrite, dest: d_dest};

  assign w_ex_a  = hit(r_ex,  d_rs, d_use_rs);
  assign w_mem_a = hit(r_mem, d_rs, d_use_rs);
  assign w_wb_a  = hit(r_wb,  d_rs, d_use_rs);
  assign w_ex_b  = hit(r_ex,  d_rt, d_use_rt);
  assign w_mem_b = hit(r_mem, d_rt, d_use_rt);
  assign w_wb_b  = hit(r_wb,  d_rt, d_use_rt);

  assign fwd_sel_a = pick_sel(w_ex_a, w_mem_a, w_wb_a);
  assign fwd_sel_b = pick_sel(w_ex_b, w_mem_b, w_wb_b);

  always_comb begin
    fwd_a = d_rs_data;
    case (fwd_sel_a)
      2'd3:    fwd_a = ex_result;
      2'd2:    fwd_a = mem_result;
      2'd1:    fwd_a = wb_result;
      default: fwd_a = d_rs_data;
    endcase
  end

  always_comb begin
    fwd_b = d_rt_data;
    case (fwd_sel_b)
      2'd3:    fwd_b = ex_result;
      2'd2:    fwd_b = mem_result;
      2'd1:    fwd_b = wb_result;
      default: fwd_b = d_rt_data;
    endcase
  end

  // Hold dominates; a flush turns a pending load-use stall into a plain bubble.
  assign w_load_use = d_valid & r_ex.memread & (w_ex_a | w_ex_b);
  assign mem_hold   = (r_hold_cnt != '0);
  assign flush_fd   = ~SYS_reset & (ex_branch_taken | (r_flush_cnt != '0));
  assign stall_fd   = w_load_use & ~flush_fd & ~mem_hold;
  assign bubble_ex  = (w_load_use | flush_fd) & ~mem_hold;

  always_ff @(negedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_hold_cnt  <= '0;
      r_flush_cnt <= '0;
    end else if (!mem_hold) begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= (stall_fd | flush_fd | ~d_valid) ? '0 : w_d_entry;
      if (r_ex.valid & r_ex.memop)
        r_hold_cnt <= c_hold_load;
      if (ex_branch_taken)
        r_flush_cnt <= c_flush_load;
      else if (r_flush_cnt != '0)
        r_flush_cnt <= r_flush_cnt - c_flush_w'(1);
    end else begin
      r_hold_cnt <= r_hold_cnt - c_hold_w'(1);
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(negedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_hold_cnt  <= '0;
    end else begin
      if (stall_fd && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush_fd && (perf_flush_cnt != '1)) perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (mem_hold && (perf_hold_cnt  != '1)) perf_hold_cnt  <= perf_hold_cnt  + 32'd1;
    end
  end
`endif

  assign w_unused = ^{r_mem.memread, r_mem.memop, r_wb.memread, r_wb.memop};

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_forward_unit
// Brief   : Directed plus randomized bench for hazard_forward_unit with an
//           in-bench pipeline model. Rev 1.0
// ============================================================================
module tb_hazard_forward_unit;
  localparam int DW = 32, AW = 5, LAT = 3, FD = 2;

  logic SYS_clk = 1'b0, SYS_reset;
  logic d_valid, d_use_rs, d_use_rt, d_regwrite, d_memread, d_memwrite;
  logic [AW-1:0] d_rs, d_rt, d_dest;
  logic [DW-1:0] d_rs_data, d_rt_data, ex_result, mem_result, wb_result;
  logic ex_branch_taken;
  logic stall_fd, bubble_ex, flush_fd, mem_hold;
  logic [1:0] fwd_sel_a, fwd_sel_b;
  logic [DW-1:0] fwd_a, fwd_b;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_hold_cnt;
`endif

  hazard_forward_unit #(.DATA_W(DW), .REG_AW(AW), .MEM_LATENCY(LAT), .FLUSH_DEPTH(FD)) dut (
    .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_regwrite(d_regwrite), .d_memread(d_memread),
    .d_memwrite(d_memwrite), .d_dest(d_dest), .d_rs_data(d_rs_data), .d_rt_data(d_rt_data),
    .ex_result(ex_result), .mem_result(mem_result), .wb_result(wb_result),
    .ex_branch_taken(ex_branch_taken), .stall_fd(stall_fd), .bubble_ex(bubble_ex),
    .flush_fd(flush_fd), .mem_hold(mem_hold), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef HAZ_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
    .perf_hold_cnt(perf_hold_cnt)
`endif
  );

  always #5 SYS_clk = ~SYS_clk;

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB; counts of remaining hold/flush cycles.
  typedef struct {bit v; bit rw; bit mr; bit mo; int dest;} ent_t;
  ent_t pipe[3];
  int   hold_left = 0, flush_left = 0;
  int   m_pstall = 0, m_pflush = 0, m_phold = 0;
  bit   mem_in;
  bit   e_stall, e_bubble, e_flush, e_hold;
  int   e_sel_a, e_sel_b;
  logic [DW-1:0] e_fwd_a, e_fwd_b;

  function automatic int sel_for(input int src, input bit use_b);
    if (SYS_reset) return 0;
    for (int s = 0; s < 3; s++)
      if (pipe[s].v && pipe[s].rw && pipe[s].dest == src && src != 0 && use_b) return 3 - s;
    return 0;
  endfunction

  function automatic logic [DW-1:0] pick(input int sel, input logic [DW-1:0] rf);
    return sel == 3 ? ex_result : sel == 2 ? mem_result : sel == 1 ? wb_result : rf;
  endfunction

  function automatic void eval();
    bit lu;
    e_sel_a = sel_for(int'(d_rs), d_use_rs);
    e_sel_b = sel_for(int'(d_rt), d_use_rt);
    e_fwd_a = pick(e_sel_a, d_rs_data);
    e_fwd_b = pick(e_sel_b, d_rt_data);
    e_hold  = !SYS_reset && hold_left > 0;
    e_flush = !SYS_reset && (ex_branch_taken || flush_left > 0);
    lu = !SYS_reset && d_valid && pipe[0].mr && (e_sel_a == 3 || e_sel_b == 3);
    e_stall  = lu && !e_flush && !e_hold;
    e_bubble = (lu || e_flush) && !e_hold;
  endfunction

  always @(negedge SYS_clk) begin
    eval();
    if (SYS_reset) begin
      foreach (pipe[i]) pipe[i] = '{default: 0};
      hold_left = 0; flush_left = 0;
      m_pstall = 0; m_pflush = 0; m_phold = 0;
    end else begin
      m_pstall += int'(e_stall); m_pflush += int'(e_flush); m_phold += int'(e_hold);
      if (e_hold) hold_left--;
      else begin
        mem_in  = pipe[0].v && pipe[0].mo;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (e_stall || e_flush || !d_valid) pipe[0] = '{default: 0};
        else pipe[0] = '{1, d_regwrite, d_memread, d_memread | d_memwrite, int'(d_dest)};
        if (mem_in) hold_left = LAT - 1;
        if (ex_branch_taken) flush_left = FD - 1;
        else if (flush_left > 0) flush_left--;
      end
    end
  end

  always @(posedge SYS_clk) begin
    eval();
    chk("stall_fd", {31'd0, stall_fd}, {31'd0, e_stall});
    chk("bubble_ex", {31'd0, bubble_ex}, {31'd0, e_bubble});
    chk("flush_fd", {31'd0, flush_fd}, {31'd0, e_flush});
    chk("mem_hold", {31'd0, mem_hold}, {31'd0, e_hold});
    chk("fwd_sel_a", {30'd0, fwd_sel_a}, e_sel_a);
    chk("fwd_sel_b", {30'd0, fwd_sel_b}, e_sel_b);
    chk("fwd_a", fwd_a, e_fwd_a);
    chk("fwd_b", fwd_b, e_fwd_b);
`ifdef HAZ_PERF_CNT_EN
    chk("perf_stall", perf_stall_cnt, m_pstall);
    chk("perf_flush", perf_flush_cnt, m_pflush);
    chk("perf_hold", perf_hold_cnt, m_phold);
`endif
  end

  task automatic nxt();
    @(negedge SYS_clk); #1;
  endtask

  task automatic mid();
    @(posedge SYS_clk); #1;
  endtask

  task automatic set_d(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                       input bit rw, input bit mr, input bit mw, input int dest);
    d_valid = v; d_rs = AW'(rs); d_rt = AW'(rt); d_use_rs = urs; d_use_rt = urt;
    d_regwrite = rw; d_memread = mr; d_memwrite = mw; d_dest = AW'(dest);
  endtask

  task automatic idle(input int n);
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) nxt();
  endtask

  int cnt_f, cnt_b, cnt_h;

  initial begin
    SYS_reset = 1'b1; ex_branch_taken = 1'b1;
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
    d_rs_data = 32'h1111; d_rt_data = 32'h2222;
    ex_result = '0; mem_result = '0; wb_result = '0;
    mid();
    chk("reset_flush", {31'd0, flush_fd}, 32'd0);
    chk("reset_fwd_a", fwd_a, 32'h1111);
    nxt(); ex_branch_taken = 1'b0; nxt(); SYS_reset = 1'b0;
    nxt();

    // add r8,r1,r2 ; sub r9,r8,r3
    set_d(1, 1, 2, 1, 1, 1, 0, 0, 8); d_rs_data = 5; d_rt_data = 7;
    nxt();
    set_d(1, 8, 3, 1, 1, 1, 0, 0, 9); d_rs_data = 0; ex_result = 12;
    mid();
    chk("s1_sel_a", {30'd0, fwd_sel_a}, 32'd3);
    chk("s1_fwd_a", fwd_a, 32'd12);
    chk("s1_stall", {31'd0, stall_fd}, 32'd0);
    idle(5);

    // lw r8,0(r0) ; add r9,r8,r8
    set_d(1, 0, 0, 1, 0, 1, 1, 0, 8);
    nxt();
    set_d(1, 8, 8, 1, 1, 1, 0, 0, 9); mem_result = 32'h55;
    mid();
    chk("s2_stall", {31'd0, stall_fd}, 32'd1);
    chk("s2_bubble", {31'd0, bubble_ex}, 32'd1);
    nxt(); mid();
    chk("s2_sel_a", {30'd0, fwd_sel_a}, 32'd2);
    chk("s2_sel_b", {30'd0, fwd_sel_b}, 32'd2);
    chk("s2_fwd_a", fwd_a, 32'h55);
    chk("s2_fwd_b", fwd_b, 32'h55);
    idle(8);

    // add r0,r1,r2 ; use r0
    set_d(1, 1, 2, 1, 1, 1, 0, 0, 0);
    nxt();
    set_d(1, 0, 5, 1, 1, 1, 0, 0, 9); d_rs_data = 0; ex_result = 32'hdead;
    mid();
    chk("s3_sel_a", {30'd0, fwd_sel_a}, 32'd0);
    chk("s3_fwd_a", fwd_a, 32'd0);
    chk("s3_stall", {31'd0, stall_fd}, 32'd0);
    idle(5);

    // one-cycle taken branch: flush for FD cycles
    ex_branch_taken = 1'b1; cnt_f = 0; cnt_b = 0;
    for (int i = 0; i < 6; i++) begin
      mid();
      cnt_f += int'(flush_fd); cnt_b += int'(bubble_ex);
      nxt();
      ex_branch_taken = 1'b0;
    end
    chk("s4_flush_cycles", cnt_f, 32'd2);
    chk("s4_bubble_cycles", cnt_b, 32'd2);

    // branch coincident with load-use
    set_d(1, 0, 0, 1, 0, 1, 1, 0, 8);
    nxt();
    set_d(1, 8, 8, 1, 1, 1, 0, 0, 9); ex_branch_taken = 1'b1;
    mid();
    chk("s4_lu_stall", {31'd0, stall_fd}, 32'd0);
    chk("s4_lu_bubble", {31'd0, bubble_ex}, 32'd1);
    chk("s4_lu_flush", {31'd0, flush_fd}, 32'd1);
    nxt(); ex_branch_taken = 1'b0;
    idle(10);

    // store reaching MEM holds LAT-1 cycles
    set_d(1, 1, 2, 1, 1, 0, 0, 1, 0);
    nxt();
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0); cnt_h = 0;
    for (int i = 0; i < 6; i++) begin
      mid(); cnt_h += int'(mem_hold); nxt();
    end
    chk("s5_hold_cycles", cnt_h, 32'd2);

    // reset in the middle of a hold
    set_d(1, 1, 2, 1, 1, 0, 0, 1, 0);
    nxt(); idle(1);
    mid();
    chk("s5_hold_on", {31'd0, mem_hold}, 32'd1);
    SYS_reset = 1'b1; #1;
    chk("s5_hold_drop", {31'd0, mem_hold}, 32'd0);
    nxt(); nxt(); SYS_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("s5_post_hold", {31'd0, mem_hold}, 32'd0);
      chk("s5_post_stall", {31'd0, stall_fd}, 32'd0);
      nxt();
    end

    // randomized traffic over a small register set to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      nxt();
      set_d($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3));
      d_rs_data  = $urandom; d_rt_data  = $urandom;
      ex_result  = $urandom; mem_result = $urandom; wb_result = $urandom;
      ex_branch_taken = $urandom_range(0, 9) == 0;
      SYS_reset = $urandom_range(0, 499) == 0;
    end
    nxt(); SYS_reset = 1'b0; idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
